// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction fetch controller feeding a 4-entry
// {pc, instruction} queue from a dual-read instruction memory.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   mem_addr1/2              byte addresses fetch_pc and fetch_pc+4 (comb)
//   mem_data1/2              combinational read data for mem_addr1/2
//   redirect_valid/_pc       branch/jump redirect; flushes the queue
//   inst_valid/_ready        consumer handshake for the queue head
//   inst_data/_pc            queue head instruction and its byte address
//   halted                   fetch ran past LAST_ADDR and queue drained
//   occupancy                queue entries held (0..4)
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] LAST_ADDR = 32'd220
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr1,
  output logic [31:0] mem_addr2,
  input  logic [31:0] mem_data1,
  input  logic [31:0] mem_data2,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        halted,
  output logic [2:0]  occupancy
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fq_entry_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [2:0]  occ;
  logic [1:0]  rd_ptr, wr_ptr;
  fq_entry_t   fq [4];

  logic [32:0] pc_p4;
  logic [2:0]  free;
  logic        fetching, can_pair, can_one, push1, push2, pop, flush;
  logic [2:0]  n_push;

  // Low address bits are dropped on redirect (word alignment).
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

  assign mem_addr1 = fetch_pc;
  assign mem_addr2 = fetch_pc + 32'd4;

  // 33-bit compare so fetch_pc near 2^32 cannot wrap into the valid range.
  assign pc_p4    = {1'b0, fetch_pc} + 33'd4;
  // Free slots use pre-pop occupancy: a full queue stalls one cycle even
  // while popping, which also guarantees push never overwrites the head.
  assign free     = 3'd4 - occ;
  assign fetching = (state == FETCH) && !redirect_valid;
  assign can_pair = (free >= 3'd2) && (pc_p4 <= {1'b0, LAST_ADDR});
  assign can_one  = (free >= 3'd1) && (fetch_pc <= LAST_ADDR);
  assign push2    = fetching && can_pair;
  assign push1    = fetching && !can_pair && can_one;
  assign n_push   = push2 ? 3'd2 : (push1 ? 3'd1 : 3'd0);

  assign flush      = redirect_valid && (state != IDLE);
  assign inst_valid = (occ != 3'd0) && !redirect_valid;
  assign pop        = inst_valid && inst_ready;

  assign inst_data = fq[rd_ptr].ins;
  assign inst_pc   = fq[rd_ptr].pc;
  assign halted    = (state == HALT) && (occ == 3'd0);
  assign occupancy = occ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      occ      <= 3'd0;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH, HALT: begin
          if (flush) begin
            occ      <= 3'd0;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            state    <= FETCH;
          end else begin
            occ    <= occ + n_push - {2'b00, pop};
            rd_ptr <= rd_ptr + {1'b0, pop};
            wr_ptr <= wr_ptr + n_push[1:0];
            if (push2)      fetch_pc <= fetch_pc + 32'd8;
            else if (push1) fetch_pc <= fetch_pc + 32'd4;
            if (state == FETCH && fetch_pc > LAST_ADDR) state <= HALT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Queue storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push1 || push2) fq[wr_ptr] <= '{pc: fetch_pc, ins: mem_data1};
    if (push2) fq[wr_ptr + 2'd1] <= '{pc: mem_addr2, ins: mem_data2};
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr1, mem_addr2, mem_data1, mem_data2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready, halted;
  logic [31:0] inst_data, inst_pc;
  logic [2:0]  occupancy;

  int n_chk  = 0;
  int n_fail = 0;

  inst_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_data1(mem_data1), .mem_data2(mem_data2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .halted(halted), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign mem_data1 = memf(mem_addr1);
  assign mem_data2 = memf(mem_addr2);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] exp_pc, last_pc;
    rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    // reset state
    tick(); tick();
    chk("rst_occ", {29'd0, occupancy}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addr1", mem_addr1, 32'd0);
    chk("rst_addr2", mem_addr2, 32'd4);

    // release; redirect during IDLE must be ignored
    rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0; #1;
    chk("idle_redir_pc", mem_addr1, 32'd0);
    chk("fetch1_occ", {29'd0, occupancy}, 32'd0);
    chk("fetch1_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("first_valid", {31'd0, inst_valid}, 32'd1);
    chk("first_occ", {29'd0, occupancy}, 32'd2);
    chk("first_pc", inst_pc, 32'd0);
    chk("first_data", inst_data, memf(32'd0));
    chk("first_addr1", mem_addr1, 32'd8);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("stream_pc", inst_pc, 32'(4 * k));
      chk("stream_valid", {31'd0, inst_valid}, 32'd1);
    end
    chk("steady_occ", {29'd0, occupancy}, 32'd3);

    // reset mid-stream
    rst_n = 1'b0; inst_ready = 1'b0;
    tick();
    chk("midrst_occ", {29'd0, occupancy}, 32'd0);
    chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
    chk("midrst_pc", mem_addr1, 32'd0);

    // backpressure: queue saturates at 4, fetch_pc parks at 16
    rst_n = 1'b1;
    repeat (10) tick();
    chk("bp_occ", {29'd0, occupancy}, 32'd4);
    chk("bp_fetchpc", mem_addr1, 32'd16);
    inst_ready = 1'b1; #1;
    for (int k = 0; k <= 4; k++) begin
      chk("bp_drain_pc", inst_pc, 32'(4 * k));
      chk("bp_drain_data", inst_data, memf(32'(4 * k)));
      tick();
      if (k == 0) begin
        chk("full_stall_occ", {29'd0, occupancy}, 32'd3);
        chk("full_stall_pc", mem_addr1, 32'd16);
      end
    end

    // redirect with 3 entries queued
    chk("pre_redir_occ", {29'd0, occupancy}, 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h43; #1;
    chk("redir_valid_mask", {31'd0, inst_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("redir_occ", {29'd0, occupancy}, 32'd0);
    chk("redir_valid", {31'd0, inst_valid}, 32'd0);
    chk("redir_align", mem_addr1, 32'h40);
    tick();
    chk("redir_pc", inst_pc, 32'h40);
    chk("redir_data", inst_data, memf(32'h40));

    // run to the end of the program
    exp_pc = 32'h44; last_pc = 32'h40;
    for (int c = 0; c < 200 && !halted; c++) begin
      tick();
      if (inst_valid) begin
        chk("seq_pc", inst_pc, exp_pc);
        last_pc = inst_pc;
        exp_pc  = exp_pc + 32'd4;
      end
    end
    chk("end_halted", {31'd0, halted}, 32'd1);
    chk("end_last_pc", last_pc, 32'd220);
    repeat (3) tick();
    chk("halt_occ", {29'd0, occupancy}, 32'd0);
    chk("halt_stay", {31'd0, halted}, 32'd1);
    chk("halt_fetchpc", mem_addr1, 32'd224);

    // redirect out of HALT
    redirect_valid = 1'b1; redirect_pc = 32'd8;
    tick();
    redirect_valid = 1'b0; #1;
    chk("resume_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("resume_valid", {31'd0, inst_valid}, 32'd1);
    chk("resume_pc0", inst_pc, 32'd8);
    tick();
    chk("resume_pc1", inst_pc, 32'd12);

    // redirect to the last word: only a single push fits below LAST_ADDR
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd220;
    tick();
    redirect_valid = 1'b0; #1;
    tick();
    chk("last_single_occ", {29'd0, occupancy}, 32'd1);
    chk("last_single_pc", inst_pc, 32'd220);
    tick();
    chk("last_halt_pending", {31'd0, halted}, 32'd0);
    chk("last_no_push", {29'd0, occupancy}, 32'd1);
    inst_ready = 1'b1;
    tick();
    chk("last_halted", {31'd0, halted}, 32'd1);

    // redirect past LAST_ADDR: FETCH then HALT, nothing pushed
    redirect_valid = 1'b1; redirect_pc = 32'd224;
    tick();
    redirect_valid = 1'b0; #1;
    chk("oob_halted0", {31'd0, halted}, 32'd0);
    tick();
    chk("oob_halted1", {31'd0, halted}, 32'd1);
    chk("oob_occ", {29'd0, occupancy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch byte address after reset.
REQ-002 The block SHALL have parameter LAST_ADDR, default 32'd220, byte address of the last valid instruction word (entry 55).
REQ-003 The block SHALL have port clk, input, 1 bit, single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 The block SHALL have ports mem_addr1 and mem_addr2, output, 32 bits each, byte addresses to the dual-read instruction memory.
REQ-006 The block SHALL have ports mem_data1 and mem_data2, input, 32 bits each, combinational read data for mem_addr1 and mem_addr2.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit, branch/jump redirect strobe.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits, redirect target byte address.
REQ-009 The block SHALL have port inst_valid, output, 1 bit, instruction available to consumer.
REQ-010 The block SHALL have port inst_ready, input, 1 bit, consumer accepts instruction.
REQ-011 The block SHALL have ports inst_data and inst_pc, output, 32 bits each, head-of-queue instruction and its byte address.
REQ-012 The block SHALL have port halted, output, 1 bit, fetch ended past LAST_ADDR and queue empty.
REQ-013 The block SHALL have port occupancy, output, 3 bits, queue entries held (0..4).

Function
REQ-014 The block SHALL hold a fetch_pc register and a 4-entry FIFO of {pc, instruction} pairs.
REQ-015 mem_addr1 SHALL equal fetch_pc and mem_addr2 SHALL equal fetch_pc+4, both combinational.
REQ-016 The state machine SHALL have states IDLE, FETCH, HALT; IDLE entered on reset, FETCH entered unconditionally on the next cycle.
REQ-017 In FETCH without redirect, with free = 4 - occupancy: if free>=2 and fetch_pc+4<=LAST_ADDR, push mem_data1 then mem_data2 and fetch_pc += 8; else if free>=1 and fetch_pc<=LAST_ADDR, push mem_data1 and fetch_pc += 4; else push nothing.
REQ-018 The free count SHALL use occupancy before the same-cycle pop, so a full queue stalls fetch one cycle even when popping.
REQ-019 inst_valid SHALL be (occupancy!=0) and not redirect_valid; pop occurs when inst_valid and inst_ready.
REQ-020 occupancy SHALL update to occupancy + pushes - pop each cycle; in-order delivery; push writes and pop reads in one cycle SHALL not conflict.
REQ-021 Fetch-to-inst_valid latency SHALL be one cycle (pushed words visible the cycle after).
REQ-022 In FETCH, when fetch_pc > LAST_ADDR, the state SHALL move to HALT; queued entries continue to drain.
REQ-023 halted SHALL be 1 when state is HALT and occupancy is 0.
REQ-024 redirect_valid in any state except IDLE SHALL take priority: flush queue (occupancy 0), no push or pop that cycle, fetch_pc <= {redirect_pc[31:2],2'b00}, state FETCH next cycle.
REQ-025 A redirect target > LAST_ADDR SHALL result in FETCH then HALT on the following cycle with nothing pushed.
REQ-026 redirect_valid during IDLE SHALL be ignored.
REQ-027 inst_data/inst_pc SHALL show the head entry; they are don't-care when inst_valid is 0.

Reset
REQ-028 rst_n low at a clock edge SHALL set state IDLE, fetch_pc RESET_PC, occupancy 0, inst_valid 0, halted 0, aborting any operation in progress.
REQ-029 FIFO storage contents SHALL not require reset.

Verification
REQ-030 Reset release, inst_ready=1 -> cycle 1 pushes pc 0 and 4; inst_pc sequence 0,4,8,... one per cycle, no bubble after first.
REQ-031 inst_ready=0 for 10 cycles -> occupancy saturates at 4, fetch_pc stops at 16; release -> pc 0..12 delivered in order, then 16.
REQ-032 Redirect to 32'h0000_0043 with 3 entries queued -> occupancy 0 next cycle, next inst_pc 32'h40, old entries never delivered.
REQ-033 Sequential run to end -> last delivered inst_pc 220, odd-word single push at 220, halted=1 after drain, no further pushes.
REQ-034 In HALT, redirect to 8 -> halted 0, delivery resumes at pc 8; redirect to 224 -> halted 1 within two cycles.
REQ-035 rst_n low mid-stream with occupancy 3 -> next cycle occupancy 0, inst_valid 0, fetch restarts at RESET_PC.
